// File: rtl/onebit_pkg.sv
// Shared constants and loader state encoding for the 1-bit processor slice.
package onebit_pkg;

  localparam int INSTR_W   = 13;
  localparam int INSTR_MEM = 16;
  localparam int IN_REGS   = 2;
  localparam int OUT_REGS  = 7;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_PROC = 3'd1,
    FETCH      = 3'd2,
    SHIFT      = 3'd3,
    RUN        = 3'd4
  } ld_state_e;

endpackage

// File: rtl/onebit_piso.sv
// Parallel-load, MSB-first shift register; bit_o is the current bit, last_o flags bit 0.
module onebit_piso #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  output logic         bit_o,
  output logic         last_o
);

  localparam int BC_W = $clog2(W);

  logic [W-1:0]    shreg_q;
  logic [BC_W-1:0] bit_cnt_q;

  // Bits are indexed rather than shifted so the word stays intact for debug.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (load_i) begin
      shreg_q   <= data_i;
      bit_cnt_q <= BC_W'(W - 1);
    end else if (shift_i && (bit_cnt_q != '0)) begin
      bit_cnt_q <= bit_cnt_q - 1'b1;
    end
  end

  assign bit_o  = shreg_q[bit_cnt_q];
  assign last_o = (bit_cnt_q == '0);

endmodule

// File: rtl/onebit_prog_loader.sv
// Sequences a OneBitProcessor through reset, serial program load (MSB-first on IN0) and run.
module onebit_prog_loader #(
  parameter int INSTR_W      = onebit_pkg::INSTR_W,
  parameter int INSTR_MEM    = onebit_pkg::INSTR_MEM,
  parameter int IN_REGS      = onebit_pkg::IN_REGS,
  parameter int LEN_W        = 5,
  parameter int RESET_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   prog_len,
  input  logic [INSTR_W-1:0] word_data,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic [IN_REGS-1:0] user_in,
  output logic               proc_reset,
  output logic               proc_en,
  output logic [IN_REGS-1:0] proc_in,
  output logic               busy,
  output logic               loaded,
  output logic               error
);

  import onebit_pkg::*;

  localparam int RC_W = $clog2(RESET_CYCLES + 1);

  ld_state_e        state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_cnt_q;
  logic [RC_W-1:0]  rst_cnt_q;
  logic             error_q;

  logic piso_load, piso_shift, piso_bit, piso_last;
  logic len_bad;

  assign len_bad    = (prog_len == '0) || (prog_len > LEN_W'(INSTR_MEM));
  assign piso_load  = (state_q == FETCH) && word_valid;
  assign piso_shift = (state_q == SHIFT);

  onebit_piso #(.W(INSTR_W)) u_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (piso_load),
    .data_i  (word_data),
    .shift_i (piso_shift),
    .bit_o   (piso_bit),
    .last_o  (piso_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      rst_cnt_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (start) begin
            if (len_bad) begin
              error_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              len_q      <= prog_len;
              error_q    <= 1'b0;
              word_cnt_q <= '0;
              rst_cnt_q  <= '0;
              state_q    <= RESET_PROC;
            end
          end
        end
        RESET_PROC: begin
          if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
            rst_cnt_q <= '0;
            state_q   <= FETCH;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        FETCH: begin
          if (word_valid) state_q <= SHIFT;
        end
        SHIFT: begin
          if (piso_last) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            state_q    <= (word_cnt_q + 1'b1 == len_q) ? RUN : FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign word_ready = (state_q == FETCH);
  assign proc_reset = (state_q == RESET_PROC);
  assign proc_en    = (state_q == SHIFT);
  assign busy       = (state_q == RESET_PROC) || (state_q == FETCH) || (state_q == SHIFT);
  assign loaded     = (state_q == RUN);
  assign error      = error_q;

  // user_in reaches the processor only once the program is resident.
  always_comb begin
    proc_in = '0;
    if (state_q == SHIFT)    proc_in[0] = piso_bit;
    else if (state_q == RUN) proc_in    = user_in;
  end

endmodule

// File: tb/tb_onebit_prog_loader.sv
// Directed bench for onebit_prog_loader: reset, loads, stall, bad length, mid-load reset, run.
module tb_onebit_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  prog_len = '0;
  logic [12:0] word_data = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [1:0]  user_in = '0;
  logic        proc_reset, proc_en, busy, loaded, error;
  logic [1:0]  proc_in;

  int checks = 0;
  int failures = 0;

  int          en_cnt = 0;
  int          prst_cnt = 0;
  logic [63:0] cap = '0;

  onebit_prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_len   (prog_len),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .user_in    (user_in),
    .proc_reset (proc_reset),
    .proc_en    (proc_en),
    .proc_in    (proc_in),
    .busy       (busy),
    .loaded     (loaded),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Stand-in for the processor's load port: collect IN0 whenever en is high.
  always @(negedge clk) begin
    if (proc_en) begin
      cap    <= {cap[62:0], proc_in[0]};
      en_cnt <= en_cnt + 1;
    end
    if (proc_reset) prst_cnt <= prst_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] len);
    prog_len = len;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic offer(input logic [12:0] w);
    bit got = 1'b0;
    word_data  = w;
    word_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (word_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("offer_accept", 64'(got), 64'd1);
    if (got) step();
  endtask

  task automatic wait_ready();
    bit got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (word_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_ready", 64'(got), 64'd1);
  endtask

  task automatic wait_loaded();
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (loaded) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_loaded", 64'(got), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e0, p0, p1;
    bit  en_seen;

    // Reset and idle
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_outs", {proc_reset, proc_en, proc_in, word_ready, busy, loaded, error}, 64'd0);
    chk("reset_state", 64'(dut.state_q), 64'(onebit_pkg::IDLE));

    // Two-word load, valid held high
    e0 = en_cnt; p0 = prst_cnt;
    do_start(5'd2);
    @(negedge clk);
    chk("2w_rst_c1", {proc_reset, busy, proc_en}, 3'b110);
    @(negedge clk);
    chk("2w_rst_c2", {proc_reset, word_ready}, 2'b10);
    @(negedge clk);
    chk("2w_fetch", {proc_reset, word_ready, proc_en, proc_in}, 5'b01000);
    offer(13'h1FFF);
    offer(13'h0000);
    word_valid = 1'b0;
    wait_loaded();
    chk("2w_prst_cnt", 64'(prst_cnt - p0), 64'd2);
    chk("2w_en_cnt", 64'(en_cnt - e0), 64'd26);
    chk("2w_instr0", 64'(cap[25:13]), 64'h1FFF);
    chk("2w_instr1", 64'(cap[12:0]), 64'h0000);
    chk("2w_run", {loaded, busy, proc_en, proc_reset}, 4'b1000);

    // Stall between words
    e0 = en_cnt; p0 = prst_cnt;
    do_start(5'd2);
    offer(13'h1555);
    word_valid = 1'b0;
    wait_ready();
    en_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      en_seen |= proc_en;
    end
    chk("stall_en_low", 64'(en_seen), 64'd0);
    offer(13'h0AAA);
    word_valid = 1'b0;
    wait_loaded();
    chk("stall_en_cnt", 64'(en_cnt - e0), 64'd26);
    chk("stall_stream", 64'(cap[25:0]), 64'b1010101010101_0101010101010);
    chk("stall_prst", 64'(prst_cnt - p0), 64'd2);

    // Bad lengths from RUN
    p0 = prst_cnt;
    do_start(5'd0);
    @(negedge clk);
    chk("bad0_outs", {error, loaded, busy, proc_reset}, 4'b1000);
    chk("bad0_state", 64'(dut.state_q), 64'(onebit_pkg::IDLE));
    do_start(5'd17);
    @(negedge clk);
    chk("bad17_outs", {error, loaded, busy, word_ready}, 4'b1000);
    repeat (3) @(negedge clk);
    chk("bad_no_prst", 64'(prst_cnt - p0), 64'd0);
    do_start(5'd1);
    @(negedge clk);
    chk("good_clears_err", {error, proc_reset}, 2'b01);

    // Ignored start during SHIFT
    e0 = en_cnt;
    offer(13'h1234);
    word_valid = 1'b0;
    p1 = prst_cnt;
    repeat (3) step();
    do_start(5'd3);
    wait_loaded();
    chk("ign_en_cnt", 64'(en_cnt - e0), 64'd13);
    chk("ign_stream", 64'(cap[12:0]), 64'h1234);
    chk("ign_no_prst", 64'(prst_cnt - p1), 64'd0);
    chk("ign_run", {loaded, busy}, 2'b10);

    // Reset mid-word
    do_start(5'd2);
    e0 = en_cnt;
    offer(13'h0F0F);
    word_valid = 1'b0;
    for (int i = 0; i < 50 && (en_cnt - e0) < 6; i++) @(negedge clk);
    chk("mid_bits", 64'(en_cnt - e0), 64'd6);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_outs", {proc_en, busy, loaded, word_ready, error, proc_reset, proc_in}, 64'd0);
    chk("mid_rst_state", 64'(dut.state_q), 64'(onebit_pkg::IDLE));
    reset = 1'b1;
    step();

    // RUN pass-through and reload
    do_start(5'd1);
    user_in = 2'b10;
    @(negedge clk);
    chk("no_pass_busy", 64'(proc_in), 64'd0);
    offer(13'h0001);
    word_valid = 1'b0;
    wait_loaded();
    #1;
    chk("run_pass_10", {proc_in, proc_en}, 3'b100);
    user_in = 2'b01;
    #1;
    chk("run_pass_01", 64'(proc_in), 64'd1);
    p0 = prst_cnt;
    do_start(5'd1);
    @(negedge clk);
    chk("reload_c1", {loaded, proc_reset, proc_in}, 4'b0100);
    @(negedge clk);
    chk("reload_c2", 64'(proc_reset), 64'd1);
    @(negedge clk);
    chk("reload_fetch", {proc_reset, word_ready}, 2'b01);
    chk("reload_prst", 64'(prst_cnt - p0), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
